// File: rtl/mod_countdown_timer_pkg.sv
// Shared types and modulo helpers for the cascadable countdown stage.
package mod_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [31:0] wrap_inc(
    input logic [31:0] value,
    input logic [31:0] modulus
  );
    return (value >= modulus - 32'd1) ? 32'd0 : value + 32'd1;
  endfunction

  function automatic logic [31:0] wrap_dec(
    input logic [31:0] value,
    input logic [31:0] modulus
  );
    return (value == 32'd0) ? modulus - 32'd1 : value - 32'd1;
  endfunction

endpackage

// File: rtl/mod_countdown_timer_if.sv
// Control, chain and display signals of one countdown stage.
interface mod_countdown_timer_if #(
  parameter int WIDTH = 6
);
  logic             set_mode;
  logic             inc_btn;
  logic             dec_btn;
  logic             start;
  logic             pause;
  logic             tick_in;
  logic             upper_zero_in;
  logic [WIDTH-1:0] count_out;
  logic [WIDTH-1:0] preset_out;
  logic             zero_out;
  logic             borrow_out;
  logic             done;
  logic             running;

  modport master (
    output set_mode, inc_btn, dec_btn,
    output start, pause, tick_in,
    output upper_zero_in,
    input  count_out, preset_out,
    input  zero_out, borrow_out,
    input  done, running
  );

  modport slave (
    input  set_mode, inc_btn, dec_btn,
    input  start, pause, tick_in,
    input  upper_zero_in,
    output count_out, preset_out,
    output zero_out, borrow_out,
    output done, running
  );
endinterface

// File: rtl/mod_countdown_timer_edge.sv
// Rising-edge detector: one-cycle pulse in the cycle the level goes high.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign pulse = level & ~prev;
endmodule

// File: rtl/mod_countdown_timer.sv
// Cascadable modulo countdown stage (SET/RUN/PAUSE/DONE, borrow chain).
// Define AUTO_RELOAD_EN for periodic reload on expiry.
module mod_countdown_timer
  import mod_timer_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int MODULUS     = 60,
  parameter int PRESET_INIT = 0
) (
  input logic                  clk,
  input logic                  reset,
  mod_countdown_timer_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] PINI = WIDTH'(PRESET_INIT);
  localparam logic [31:0]      MOD  = 32'(MODULUS);

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] preset_q;
  logic             borrow_q;
  logic             done_q;
  logic             inc_edge;
  logic             dec_edge;

  edge_pulse u_inc (
    .clk   (clk),
    .reset (reset),
    .level (bus.inc_btn),
    .pulse (inc_edge)
  );

  edge_pulse u_dec (
    .clk   (clk),
    .reset (reset),
    .level (bus.dec_btn),
    .pulse (dec_edge)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      preset_q <= PINI;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
      if (bus.set_mode) begin
        state_q <= ST_SET;
        if (state_q == ST_SET) begin
          if (inc_edge && !dec_edge)
            preset_q <= WIDTH'(wrap_inc(32'(preset_q), MOD));
          else if (dec_edge && !inc_edge)
            preset_q <= WIDTH'(wrap_dec(32'(preset_q), MOD));
        end
      end else begin
        unique case (state_q)
          ST_SET: state_q <= ST_IDLE;
          ST_IDLE, ST_DONE: begin
            if (bus.start) begin
              count_q <= preset_q;
              state_q <= ST_RUN;
            end
          end
          ST_PAUSE: begin
            if (bus.start) begin
              count_q <= preset_q;
              state_q <= ST_RUN;
            end else if (bus.pause) begin
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (bus.start) begin
              count_q <= preset_q;
            end else if (bus.pause) begin
              state_q <= ST_PAUSE;
            end else if (bus.tick_in) begin
              if (count_q != '0) begin
                count_q <= count_q - WIDTH'(1);
              end else if (!bus.upper_zero_in) begin
                count_q  <= MAX;
                borrow_q <= 1'b1;
              end else begin
                done_q <= 1'b1;
`ifdef AUTO_RELOAD_EN
                count_q <= preset_q;
`else
                state_q <= ST_DONE;
`endif
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.count_out  = count_q;
  assign bus.preset_out = preset_q;
  assign bus.zero_out   = (count_q == '0) && bus.upper_zero_in;
  assign bus.borrow_out = borrow_q;
  assign bus.done       = done_q;
  assign bus.running    = (state_q == ST_RUN);
endmodule

// File: tb/tb_mod_countdown_timer.sv
// Directed vector bench for mod_countdown_timer, single and chained.
module tb_mod_countdown_timer;
`ifdef AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mod_countdown_timer_if #(.WIDTH(6)) if0 ();
  mod_countdown_timer_if #(.WIDTH(6)) s_if ();
  mod_countdown_timer_if #(.WIDTH(6)) m_if ();

  mod_countdown_timer #(.WIDTH(6), .MODULUS(60), .PRESET_INIT(0)) u0 (
    .clk(clk), .reset(reset), .bus(if0));
  mod_countdown_timer #(.WIDTH(6), .MODULUS(60), .PRESET_INIT(0)) u_sec (
    .clk(clk), .reset(reset), .bus(s_if));
  mod_countdown_timer #(.WIDTH(6), .MODULUS(60), .PRESET_INIT(0)) u_min (
    .clk(clk), .reset(reset), .bus(m_if));

  assign m_if.upper_zero_in = 1'b1;
  assign m_if.tick_in       = s_if.borrow_out;
  assign s_if.upper_zero_in = m_if.zero_out;

  typedef struct {
    logic sm, inc, dec, st, pa, tk, uz;
    logic [5:0] cnt, pre;
    logic run, bor, dn, zr;
  } vec_t;

  vec_t tv[35];

  function automatic vec_t mk(
    input logic sm, inc, dec, st, pa, tk, uz,
    input logic [5:0] cnt, pre,
    input logic run, bor, dn, zr
  );
    vec_t v;
    v.sm = sm; v.inc = inc; v.dec = dec; v.st = st;
    v.pa = pa; v.tk = tk; v.uz = uz;
    v.cnt = cnt; v.pre = pre;
    v.run = run; v.bor = bor; v.dn = dn; v.zr = zr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_preset(input int n);
    if0.set_mode = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      if0.inc_btn = 1'b1; step();
      if0.inc_btn = 1'b0; step();
    end
    if0.set_mode = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    {if0.set_mode, if0.inc_btn, if0.dec_btn, if0.start,
     if0.pause, if0.tick_in, if0.upper_zero_in} = '0;
    {s_if.set_mode, s_if.inc_btn, s_if.dec_btn, s_if.start,
     s_if.pause, s_if.tick_in} = '0;
    {m_if.set_mode, m_if.inc_btn, m_if.dec_btn, m_if.start,
     m_if.pause} = '0;

    //          sm i d st pa tk uz  cnt pre run bor dn zr
    tv[0]  = mk(1,0,0,0,0,0,1,  0, 0, 0,0,0,1);
    tv[1]  = mk(1,1,0,0,0,0,1,  0, 1, 0,0,0,1);
    tv[2]  = mk(1,0,0,0,0,0,1,  0, 1, 0,0,0,1);
    tv[3]  = mk(1,1,0,0,0,0,1,  0, 2, 0,0,0,1);
    tv[4]  = mk(1,0,0,0,0,0,1,  0, 2, 0,0,0,1);
    tv[5]  = mk(1,1,0,0,0,0,1,  0, 3, 0,0,0,1);
    tv[6]  = mk(0,0,0,0,0,0,1,  0, 3, 0,0,0,1);
    tv[7]  = mk(0,0,0,1,0,0,1,  3, 3, 1,0,0,0);
    tv[8]  = mk(0,0,0,0,0,1,1,  2, 3, 1,0,0,0);
    tv[9]  = mk(0,0,0,0,0,1,1,  1, 3, 1,0,0,0);
    tv[10] = mk(0,0,0,0,0,1,1,  0, 3, 1,0,0,1);
    tv[11] = mk(0,0,0,0,0,1,0, 59, 3, 1,1,0,0);
    tv[12] = mk(0,0,0,0,0,0,0, 59, 3, 1,0,0,0);
    tv[13] = mk(0,0,0,0,1,0,1, 59, 3, 0,0,0,0);
    tv[14] = mk(0,0,0,0,0,1,1, 59, 3, 0,0,0,0);
    tv[15] = mk(0,0,0,0,1,0,1, 59, 3, 1,0,0,0);
    tv[16] = mk(0,0,0,1,0,0,1,  3, 3, 1,0,0,0);
    tv[17] = mk(0,0,0,1,0,1,1,  3, 3, 1,0,0,0);
    tv[18] = mk(0,0,0,0,0,1,1,  2, 3, 1,0,0,0);
    tv[19] = mk(1,0,0,0,0,1,1,  2, 3, 0,0,0,0);
    tv[20] = mk(1,0,1,0,0,0,1,  2, 2, 0,0,0,0);
    tv[21] = mk(1,0,0,0,0,0,1,  2, 2, 0,0,0,0);
    tv[22] = mk(1,0,1,0,0,0,1,  2, 1, 0,0,0,0);
    tv[23] = mk(1,0,0,0,0,0,1,  2, 1, 0,0,0,0);
    tv[24] = mk(1,0,1,0,0,0,1,  2, 0, 0,0,0,0);
    tv[25] = mk(1,0,0,0,0,0,1,  2, 0, 0,0,0,0);
    tv[26] = mk(1,0,1,0,0,0,1,  2,59, 0,0,0,0);
    tv[27] = mk(1,1,0,0,0,0,1,  2, 0, 0,0,0,0);
    tv[28] = mk(1,0,0,0,0,0,1,  2, 0, 0,0,0,0);
    tv[29] = mk(1,1,1,0,0,0,1,  2, 0, 0,0,0,0);
    tv[30] = mk(0,0,0,0,0,0,1,  2, 0, 0,0,0,0);
    tv[31] = mk(0,0,0,1,0,0,1,  0, 0, 1,0,0,1);
    tv[32] = mk(0,0,0,0,0,1,1,  0, 0, AR,0,1,1);
    tv[33] = mk(0,0,0,0,0,0,1,  0, 0, AR,0,0,1);
    tv[34] = mk(0,0,0,0,0,1,1,  0, 0, AR,0,AR,1);

    reset = 1'b1;
    if0.upper_zero_in = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_count", if0.count_out, 0);
    chk("rst_preset", if0.preset_out, 0);
    chk("rst_running", if0.running, 0);
    chk("rst_borrow", if0.borrow_out, 0);
    chk("rst_done", if0.done, 0);

    for (int i = 0; i < 35; i++) begin
      if0.set_mode = tv[i].sm;
      if0.inc_btn  = tv[i].inc;
      if0.dec_btn  = tv[i].dec;
      if0.start    = tv[i].st;
      if0.pause    = tv[i].pa;
      if0.tick_in  = tv[i].tk;
      if0.upper_zero_in = tv[i].uz;
      step();
      chk($sformatf("v%0d_count", i), if0.count_out, tv[i].cnt);
      chk($sformatf("v%0d_preset", i), if0.preset_out, tv[i].pre);
      chk($sformatf("v%0d_running", i), if0.running, tv[i].run);
      chk($sformatf("v%0d_borrow", i), if0.borrow_out, tv[i].bor);
      chk($sformatf("v%0d_done", i), if0.done, tv[i].dn);
      chk($sformatf("v%0d_zero", i), if0.zero_out, tv[i].zr);
    end
    {if0.start, if0.pause, if0.tick_in} = '0;
    if0.upper_zero_in = 1'b1;

    // pause freezes the count
    set_preset(10);
    if0.start = 1'b1; step(); if0.start = 1'b0;
    chk("pz_start", if0.count_out, 10);
    if0.pause = 1'b1; step(); if0.pause = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if0.tick_in = 1'b1; step();
    end
    if0.tick_in = 1'b0;
    chk("pz_frozen", if0.count_out, 10);
    chk("pz_running", if0.running, 0);
    if0.pause = 1'b1; step(); if0.pause = 1'b0;
    if0.tick_in = 1'b1; step(); if0.tick_in = 1'b0;
    chk("pz_resume", if0.count_out, 9);

    // reset wins over tick mid-run
    if0.tick_in = 1'b1; reset = 1'b1;
    step();
    if0.tick_in = 1'b0; reset = 1'b0;
    chk("mr_count", if0.count_out, 0);
    chk("mr_preset", if0.preset_out, 0);
    chk("mr_borrow", if0.borrow_out, 0);
    chk("mr_done", if0.done, 0);
    chk("mr_running", if0.running, 0);

    // chained MM:SS, min=1 sec=0
    m_if.set_mode = 1'b1; step();
    m_if.inc_btn = 1'b1; step(); m_if.inc_btn = 1'b0;
    m_if.set_mode = 1'b0; step();
    s_if.start = 1'b1; m_if.start = 1'b1; step();
    s_if.start = 1'b0; m_if.start = 1'b0;
    chk("ch_min_init", m_if.count_out, 1);
    chk("ch_sec_init", s_if.count_out, 0);
    chk("ch_sec_zero0", s_if.zero_out, 0);
    s_if.tick_in = 1'b1; step(); s_if.tick_in = 1'b0;
    chk("ch_sec_wrap", s_if.count_out, 59);
    chk("ch_borrow1", s_if.borrow_out, 1);
    step();
    chk("ch_borrow0", s_if.borrow_out, 0);
    chk("ch_min_dec", m_if.count_out, 0);
    for (int i = 0; i < 59; i++) begin
      s_if.tick_in = 1'b1; step();
      s_if.tick_in = 1'b0; step();
    end
    chk("ch_sec_end", s_if.count_out, 0);
    chk("ch_sec_zero1", s_if.zero_out, 1);
    chk("ch_done_pre", s_if.done, 0);
    s_if.tick_in = 1'b1; step(); s_if.tick_in = 1'b0;
    chk("ch_done1", s_if.done, 1);
    chk("ch_sec_cnt", s_if.count_out, 0);
    chk("ch_running", s_if.running, AR);
    step();
    chk("ch_done0", s_if.done, 0);

`ifdef AUTO_RELOAD_EN
    set_preset(2);
    if0.start = 1'b1; step(); if0.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if0.tick_in = 1'b1; step();
      chk($sformatf("ar_done_t%0d", i), if0.done, (i == 2) ? 1 : 0);
    end
    if0.tick_in = 1'b0;
    chk("ar_count", if0.count_out, 2);
    chk("ar_running", if0.running, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mod_countdown_timer.md
Name: mod_countdown_timer

Overview:
Parametrised, cascadable modulo countdown stage for the VGA timer display (seconds/minutes digits). Generalises the fixed 0..59 counter to any modulus and width. Adds a preset register adjustable up or down, explicit SET/RUN/PAUSE/DONE modes and a borrow chain, so stages can be chained MM:SS. All logic runs on one clock; there are no secondary clock edges.

Parameters:
WIDTH, 6, bit width of count and preset; must satisfy 2**WIDTH >= MODULUS
MODULUS, 60, count range 0..MODULUS-1; wrap value is MODULUS-1
PRESET_INIT, 0, preset value after reset; must be < MODULUS

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
set_mode  in  1  level; 1 = edit preset, 0 = operate
inc_btn  in  1  level, already synchronised; rising edge = preset+1
dec_btn  in  1  level, already synchronised; rising edge = preset-1
start  in  1  single-cycle pulse; loads preset into count and runs
pause  in  1  single-cycle pulse; toggles RUN<->PAUSE
tick_in  in  1  single-cycle decrement strobe (1 Hz enable, or lower stage's borrow_out)
upper_zero_in  in  1  1 when all higher stages are zero; tie 1 on the top stage
count_out  out  WIDTH  current count
preset_out  out  WIDTH  current preset, for display in SET
zero_out  out  1  count_out==0 AND upper_zero_in (chain-zero toward lower stages)
borrow_out  out  1  single-cycle pulse when count wraps 0->MODULUS-1
done  out  1  single-cycle pulse on expiry
running  out  1  1 while in RUN

Behaviour:
- Reset: state=IDLE; count_out=0; preset_out=PRESET_INIT; borrow_out=0; done=0; running=0; edge-detect registers=0.
- Button edges: internal edge_pulse gives a 1-cycle pulse on 0->1. Effect lands the cycle after the edge cycle.
- States: IDLE, SET, RUN, PAUSE, DONE.
- From any state, set_mode=1 -> SET on the next cycle. count is held, running=0.
- SET:
  - inc edge: preset wraps MODULUS-1->0, else +1.
  - dec edge: preset wraps 0->MODULUS-1, else -1.
  - inc and dec edges in the same cycle: no change.
  - set_mode=0 -> IDLE.
- IDLE/PAUSE/DONE + start (set_mode=0): count<=preset, state<=RUN, running=1 next cycle.
- RUN + tick_in:
  - count>0: count-1.
  - count==0 and upper_zero_in=0: count<=MODULUS-1; borrow_out=1 for that cycle.
  - count==0 and upper_zero_in=1: state<=DONE; done=1 for one cycle; count stays 0.
- tick_in is ignored outside RUN.
- RUN + pause -> PAUSE; PAUSE + pause -> RUN. Count is frozen while paused.
- Priority, highest first: reset > set_mode > start > pause > tick_in. start during RUN reloads preset. A tick in the same cycle as start is dropped.
- borrow_out and done are registered and asserted exactly 1 cycle. zero_out is combinational from registered count.
- Arithmetic is unsigned WIDTH-bit. No value >= MODULUS is ever stored.

Optional Feature:
AUTO_RELOAD_EN.
- Defined: on expiry, done pulses, count<=preset and the state stays RUN (periodic timer). With preset==0, done pulses on every tick.
- Undefined: expiry enters DONE and holds count=0 until start or set_mode.

Decomposition:
- Package mod_timer_pkg:
  - state enum (IDLE, SET, RUN, PAUSE, DONE), 3-bit encoding
  - function wrap_inc(value, modulus) and wrap_dec(value, modulus)
- Sub-module edge_pulse: 1-bit rising-edge detector with synchronous reset, instantiated twice (inc, dec).

Test Plan:
- Reset then set_mode=1, 3 inc edges, set_mode=0, start -> count_out=3, running=1 the cycle after start.
- Preset=59, one inc edge -> preset_out=0. Preset=0, one dec edge -> preset_out=59. Simultaneous inc+dec -> unchanged.
- Two chained stages (sec, min), min=1 sec=0, tick -> sec=59 with borrow_out 1 cycle, min=0. 59 more ticks -> sec=0, zero_out=1. Next tick -> done 1 cycle, state DONE.
- RUN count=10, pause, 5 ticks, pause, 1 tick -> count_out=9.
- reset asserted mid-RUN with tick_in=1 same cycle -> count_out=0, preset_out=PRESET_INIT, borrow_out=0, done=0.
- AUTO_RELOAD_EN defined, preset=2, upper_zero_in=1, start, 3 ticks -> done pulse on 3rd tick, count_out=2, running=1.
